controlador_parqueo_param: RTL and testbench
============================================

Name: controlador_parqueo_param

Overview:
Parametrised next-generation parking-gate controller. It handles the entry sequence (vehicle detected, BCD key entry, gate open, vehicle passes), wrong-key lockout, and the tailgating alarm. It adds a configurable key length and key value, a configurable try limit, an occupancy counter with a full flag, and a key-entry timeout. It sits between the entry-lane sensors and keypad and the gate actuator, and is a drop-in superset of the existing fixed 4-digit controller.

Parameters:
DIGITOS, 4, number of BCD digits in the key; key width is 4*DIGITOS.
CLAVE_VALIDA, 16'h0259, valid key in BCD; width 4*DIGITOS.
MAX_INTENTOS, 3, consecutive wrong keys that trigger lockout (>=1).
CAPACIDAD, 8, maximum vehicles inside (>=1).
TIMEOUT, 16, cycles allowed in key-entry state without Enter (>=2).

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  synchronous, active-high reset.
Entrada  input  1  vehicle present at entry sensor (level).
Salida  input  1  vehicle has crossed the gate sensor (level).
Enter  input  1  key-submit strobe; each high cycle is one attempt.
Clave  input  4*DIGITOS  BCD key, sampled when Enter=1.
Egreso  input  1  one-cycle pulse: a vehicle left through the exit lane.
Abrir  output  1  gate-open command.
Cerrar  output  1  gate-close command.
AlrmInt  output  1  wrong-key lockout alarm.
AlrmCom  output  1  tailgating alarm: both sensors active while the gate is open.
AlrmTiempo  output  1  one-cycle pulse on key-entry timeout.
Lleno  output  1  occupancy equals CAPACIDAD.
Ocupacion  output  $clog2(CAPACIDAD+1)  vehicles currently inside.

Behaviour:
- All outputs are registered. Every output reflects the state or event one cycle after the sampling edge.
- Reset (sync, overrides everything, including mid-operation):
  - state = ESPERA, try counter = 0, timer = 0, Ocupacion = 0.
  - Outputs: Cerrar=1, Abrir=0, AlrmInt=0, AlrmCom=0, AlrmTiempo=0, Lleno=0.
- States and Moore outputs:
  - ESPERA: Cerrar=1.
  - INGRESO: Cerrar=1.
  - ABIERTO: Abrir=1, Cerrar=0.
  - BLOQUEO: Cerrar=1, AlrmInt=1.
  - COMPUERTA: Cerrar=1, AlrmCom=1.
  - Abrir and Cerrar are never both 1.
- ESPERA:
  - Entrada=1 and Lleno=0 -> INGRESO, timer cleared.
  - Entrada=1 with Lleno=1 -> remain in ESPERA; Enter is ignored.
- INGRESO:
  - The timer increments every cycle.
  - Enter=1 and Clave==CLAVE_VALIDA -> ABIERTO; try counter cleared.
  - Enter=1 with a wrong key -> try counter +1; timer cleared.
    - If the new count equals MAX_INTENTOS -> BLOQUEO.
    - Otherwise stay in INGRESO.
  - A non-BCD digit (>9) is a wrong key.
  - Timer reaches TIMEOUT-1 with no Enter -> ESPERA; AlrmTiempo pulses for 1 cycle; try counter is kept.
  - Enter on the same cycle as the timeout wins; no timeout occurs.
- ABIERTO:
  - Salida=1 and Entrada=1 -> COMPUERTA; Ocupacion is not incremented.
  - Salida=1 and Entrada=0 -> ESPERA; Ocupacion +1 (saturates at CAPACIDAD).
- BLOQUEO and COMPUERTA:
  - Exit only on Enter=1 with the valid key -> ESPERA.
  - On that exit, the try counter is cleared and the alarm drops the next cycle.
  - Wrong keys are ignored; there is no timeout in these states.
- Egreso: Ocupacion -1 if nonzero; ignored at 0.
- Simultaneous Egreso and an ABIERTO->ESPERA increment: net change 0.
- Lleno = (Ocupacion == CAPACIDAD), updated in the same cycle as Ocupacion.
- The try counter persists across ESPERA/INGRESO cycles until a valid key or Reset.

Test Plan:
1. Reset; Entrada=1; Enter with Clave=16'h0259 -> ABIERTO: Abrir=1, Cerrar=0. Then Salida=1, Entrada=0 -> ESPERA, Ocupacion=1, Cerrar=1.
2. Three Enters with Clave=16'h1234 -> AlrmInt=1 after the 3rd. A further wrong key keeps AlrmInt=1. Clave=16'h0259 -> AlrmInt=0 and state ESPERA.
3. In ABIERTO drive Entrada=1, Salida=1 -> AlrmCom=1, Abrir=0, Ocupacion unchanged. Valid key -> AlrmCom=0.
4. CAPACIDAD=2: two full entries -> Lleno=1, and Entrada no longer opens the gate. Egreso pulse -> Ocupacion=1, Lleno=0. Egreso with Ocupacion=0 -> stays 0.
5. Entrada=1, no Enter for 16 cycles -> AlrmTiempo=1 for exactly one cycle, state ESPERA. Enter on cycle 15 -> no AlrmTiempo.
6. DIGITOS=6, CLAVE_VALIDA=24'h123456: Clave=24'h12345A -> counted wrong. Reset asserted while in ABIERTO -> next cycle Cerrar=1, Abrir=0, Ocupacion=0.

Source files
------------

// File: rtl/controlador_parqueo_param.sv
// Parametrised parking-gate controller: key entry, wrong-key lockout, tailgating alarm,
// key-entry timeout and occupancy tracking. Every output is registered.
module controlador_parqueo_param #(
    parameter int                   DIGITOS      = 4,
    parameter logic [4*DIGITOS-1:0] CLAVE_VALIDA = 16'h0259,
    parameter int                   MAX_INTENTOS = 3,
    parameter int                   CAPACIDAD    = 8,
    parameter int                   TIMEOUT      = 16
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           Entrada,
    input  logic                           Salida,
    input  logic                           Enter,
    input  logic [4*DIGITOS-1:0]           Clave,
    input  logic                           Egreso,
    output logic                           Abrir,
    output logic                           Cerrar,
    output logic                           AlrmInt,
    output logic                           AlrmCom,
    output logic                           AlrmTiempo,
    output logic                           Lleno,
    output logic [$clog2(CAPACIDAD+1)-1:0] Ocupacion
);

    localparam int OW = $clog2(CAPACIDAD + 1);
    localparam int IW = $clog2(MAX_INTENTOS + 1);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [OW-1:0] CAP_V = OW'(CAPACIDAD);
    localparam logic [IW-1:0] MAX_V = IW'(MAX_INTENTOS);
    localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT - 1);

    localparam logic [2:0] ESPERA    = 3'd0;
    localparam logic [2:0] INGRESO   = 3'd1;
    localparam logic [2:0] ABIERTO   = 3'd2;
    localparam logic [2:0] BLOQUEO   = 3'd3;
    localparam logic [2:0] COMPUERTA = 3'd4;

    // A key holding any digit above 9 never matches, even if CLAVE_VALIDA itself is malformed.
    function automatic logic es_bcd(input logic [4*DIGITOS-1:0] valor);
        logic ok;
        ok = 1'b1;
        for (int d = 0; d < DIGITOS; d++) begin
            if (valor[4*d +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [OW-1:0] inc_sat(input logic [OW-1:0] valor);
        return (valor == CAP_V) ? valor : valor + 1'b1;
    endfunction

    logic [2:0]    estado, estado_sig;
    logic [IW-1:0] intentos, intentos_sig;
    logic [TW-1:0] timer, timer_sig;
    logic          fin_tiempo;
    logic          clave_ok;
    logic          sube, baja;
    logic [OW-1:0] ocupacion_sig;

    assign clave_ok = Enter && (Clave == CLAVE_VALIDA) && es_bcd(Clave);

    always_comb begin
        estado_sig   = estado;
        intentos_sig = intentos;
        timer_sig    = timer;
        fin_tiempo   = 1'b0;
        case (estado)
            ESPERA: begin
                if (Entrada && !Lleno) begin
                    estado_sig = INGRESO;
                    timer_sig  = '0;
                end
            end
            INGRESO: begin
                timer_sig = timer + 1'b1;
                // A submission on the last allowed cycle takes priority over the timeout.
                if (Enter) begin
                    if (clave_ok) begin
                        estado_sig   = ABIERTO;
                        intentos_sig = '0;
                    end else begin
                        intentos_sig = intentos + 1'b1;
                        timer_sig    = '0;
                        if (intentos_sig >= MAX_V) estado_sig = BLOQUEO;
                    end
                end else if (timer == T_LIM) begin
                    estado_sig = ESPERA;
                    fin_tiempo = 1'b1;
                end
            end
            ABIERTO: begin
                if (Salida) estado_sig = Entrada ? COMPUERTA : ESPERA;
            end
            BLOQUEO, COMPUERTA: begin
                if (clave_ok) begin
                    estado_sig   = ESPERA;
                    intentos_sig = '0;
                end
            end
            default: estado_sig = ESPERA;
        endcase
    end

    // A car entering and one leaving on the same cycle cancel out.
    assign sube = (estado == ABIERTO) && Salida && !Entrada;
    assign baja = Egreso && (Ocupacion != '0);

    always_comb begin
        case ({sube, baja})
            2'b10:   ocupacion_sig = inc_sat(Ocupacion);
            2'b01:   ocupacion_sig = Ocupacion - 1'b1;
            default: ocupacion_sig = Ocupacion;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            estado     <= ESPERA;
            intentos   <= '0;
            timer      <= '0;
            Ocupacion  <= '0;
            Abrir      <= 1'b0;
            Cerrar     <= 1'b1;
            AlrmInt    <= 1'b0;
            AlrmCom    <= 1'b0;
            AlrmTiempo <= 1'b0;
            Lleno      <= 1'b0;
        end else begin
            estado     <= estado_sig;
            intentos   <= intentos_sig;
            timer      <= timer_sig;
            Ocupacion  <= ocupacion_sig;
            Abrir      <= (estado_sig == ABIERTO);
            Cerrar     <= (estado_sig != ABIERTO);
            AlrmInt    <= (estado_sig == BLOQUEO);
            AlrmCom    <= (estado_sig == COMPUERTA);
            AlrmTiempo <= fin_tiempo;
            Lleno      <= (ocupacion_sig == CAP_V);
        end
    end

endmodule

// File: tb/tb_controlador_parqueo_param.sv
// Directed bench for controlador_parqueo_param: a vector table on the default build,
// plus hand sequences for timeout, a two-slot lot and a six-digit key.
module tb_controlador_parqueo_param;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        rst, ent, sal, enter, egr;
    logic [15:0] clave;
    logic [23:0] clave6;

    logic       a1, c1, i1, co1, t1, l1;
    logic [3:0] o1;
    logic       a2, c2, i2, co2, t2, l2;
    logic [1:0] o2;
    logic       a3, c3, i3, co3, t3, l3;
    logic [3:0] o3;

    int checks = 0;
    int errors = 0;

    controlador_parqueo_param dut (
        .Clk(Clk), .Reset(rst), .Entrada(ent), .Salida(sal), .Enter(enter),
        .Clave(clave), .Egreso(egr), .Abrir(a1), .Cerrar(c1), .AlrmInt(i1),
        .AlrmCom(co1), .AlrmTiempo(t1), .Lleno(l1), .Ocupacion(o1)
    );

    controlador_parqueo_param #(.CAPACIDAD(2)) dut_cap2 (
        .Clk(Clk), .Reset(rst), .Entrada(ent), .Salida(sal), .Enter(enter),
        .Clave(clave), .Egreso(egr), .Abrir(a2), .Cerrar(c2), .AlrmInt(i2),
        .AlrmCom(co2), .AlrmTiempo(t2), .Lleno(l2), .Ocupacion(o2)
    );

    controlador_parqueo_param #(.DIGITOS(6), .CLAVE_VALIDA(24'h123456)) dut_dig6 (
        .Clk(Clk), .Reset(rst), .Entrada(ent), .Salida(sal), .Enter(enter),
        .Clave(clave6), .Egreso(egr), .Abrir(a3), .Cerrar(c3), .AlrmInt(i3),
        .AlrmCom(co3), .AlrmTiempo(t3), .Lleno(l3), .Ocupacion(o3)
    );

    typedef struct {
        logic [3:0]  ctl;    // reset, entrada, salida, enter
        logic [23:0] k;
        logic        g;      // egreso
        logic [5:0]  flags;  // abrir, cerrar, alrm_int, alrm_com, alrm_tiempo, lleno
        logic [3:0]  occ;
    } vec_t;

    vec_t tbl [29];

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chkn(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step(input logic [3:0] ctl, input logic [23:0] k, input logic g);
        @(negedge Clk);
        rst    = ctl[3];
        ent    = ctl[2];
        sal    = ctl[1];
        enter  = ctl[0];
        clave  = k[15:0];
        clave6 = k;
        egr    = g;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        step(4'b0000, 24'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ent = 1'b0; sal = 1'b0; enter = 1'b0; egr = 1'b0;
        clave = 16'h0; clave6 = 24'h0;

        tbl[0]  = '{4'b1000, 24'h000000, 1'b0, 6'b010000, 4'd0};
        tbl[1]  = '{4'b0100, 24'h000000, 1'b0, 6'b010000, 4'd0};
        tbl[2]  = '{4'b0001, 24'h000259, 1'b0, 6'b100000, 4'd0};
        tbl[3]  = '{4'b0010, 24'h000000, 1'b0, 6'b010000, 4'd1};
        tbl[4]  = '{4'b0100, 24'h000000, 1'b0, 6'b010000, 4'd1};
        tbl[5]  = '{4'b0001, 24'h001234, 1'b0, 6'b010000, 4'd1};
        tbl[6]  = '{4'b0001, 24'h001234, 1'b0, 6'b010000, 4'd1};
        tbl[7]  = '{4'b0001, 24'h001234, 1'b0, 6'b011000, 4'd1};
        tbl[8]  = '{4'b0001, 24'h001234, 1'b0, 6'b011000, 4'd1};
        tbl[9]  = '{4'b0000, 24'h001234, 1'b0, 6'b011000, 4'd1};
        tbl[10] = '{4'b0001, 24'h000259, 1'b0, 6'b010000, 4'd1};
        tbl[11] = '{4'b0100, 24'h000000, 1'b0, 6'b010000, 4'd1};
        tbl[12] = '{4'b0001, 24'h000259, 1'b0, 6'b100000, 4'd1};
        tbl[13] = '{4'b0110, 24'h000000, 1'b0, 6'b010100, 4'd1};
        tbl[14] = '{4'b0001, 24'h001234, 1'b0, 6'b010100, 4'd1};
        tbl[15] = '{4'b0001, 24'h000259, 1'b0, 6'b010000, 4'd1};
        tbl[16] = '{4'b0000, 24'h000000, 1'b1, 6'b010000, 4'd0};
        tbl[17] = '{4'b0000, 24'h000000, 1'b1, 6'b010000, 4'd0};
        tbl[18] = '{4'b0100, 24'h000000, 1'b0, 6'b010000, 4'd0};
        tbl[19] = '{4'b0001, 24'h00025F, 1'b0, 6'b010000, 4'd0};
        tbl[20] = '{4'b0001, 24'h000259, 1'b0, 6'b100000, 4'd0};
        tbl[21] = '{4'b0010, 24'h000000, 1'b0, 6'b010000, 4'd1};
        tbl[22] = '{4'b0100, 24'h000000, 1'b0, 6'b010000, 4'd1};
        tbl[23] = '{4'b0001, 24'h000259, 1'b0, 6'b100000, 4'd1};
        tbl[24] = '{4'b0010, 24'h000000, 1'b1, 6'b010000, 4'd1};
        tbl[25] = '{4'b0100, 24'h000000, 1'b0, 6'b010000, 4'd1};
        tbl[26] = '{4'b0001, 24'h000259, 1'b0, 6'b100000, 4'd1};
        tbl[27] = '{4'b1100, 24'h000000, 1'b0, 6'b010000, 4'd0};
        tbl[28] = '{4'b0001, 24'h000259, 1'b0, 6'b010000, 4'd0};

        for (int i = 0; i < 29; i++) begin
            step(tbl[i].ctl, tbl[i].k, tbl[i].g);
            chk1($sformatf("v%0d_abrir", i),  a1,  tbl[i].flags[5]);
            chk1($sformatf("v%0d_cerrar", i), c1,  tbl[i].flags[4]);
            chk1($sformatf("v%0d_alrmint", i), i1, tbl[i].flags[3]);
            chk1($sformatf("v%0d_alrmcom", i), co1, tbl[i].flags[2]);
            chk1($sformatf("v%0d_alrmtiempo", i), t1, tbl[i].flags[1]);
            chk1($sformatf("v%0d_lleno", i),  l1,  tbl[i].flags[0]);
            chkn($sformatf("v%0d_ocupacion", i), o1, tbl[i].occ);
        end

        // Timeout: 16 idle cycles in INGRESO, single-cycle pulse, back in ESPERA.
        step(4'b0100, 24'h0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            idle();
            chk1($sformatf("to_quiet%0d", i), t1, 1'b0);
        end
        idle();
        chk1("to_pulse", t1, 1'b1);
        chk1("to_cerrar", c1, 1'b1);
        step(4'b0001, 24'h000259, 1'b0);
        chk1("to_pulse_end", t1, 1'b0);
        chk1("to_espera_ignores_enter", a1, 1'b0);

        // Enter on the final allowed cycle beats the timeout.
        step(4'b0100, 24'h0, 1'b0);
        for (int i = 0; i < 15; i++) idle();
        step(4'b0001, 24'h001234, 1'b0);
        chk1("late_enter_no_pulse", t1, 1'b0);
        idle();
        chk1("late_enter_timer_cleared", t1, 1'b0);
        step(4'b0001, 24'h000259, 1'b0);
        chk1("late_enter_still_ingreso", a1, 1'b1);
        step(4'b0010, 24'h0, 1'b0);
        chkn("late_enter_ocup", o1, 4'd1);

        // Try counter survives a timeout: 2 wrong, timeout, 1 wrong -> lockout.
        step(4'b0100, 24'h0, 1'b0);
        step(4'b0001, 24'h001234, 1'b0);
        step(4'b0001, 24'h001234, 1'b0);
        chk1("persist_no_lock_yet", i1, 1'b0);
        for (int i = 0; i < 15; i++) idle();
        idle();
        chk1("persist_timeout", t1, 1'b1);
        step(4'b0100, 24'h0, 1'b0);
        step(4'b0001, 24'h001234, 1'b0);
        chk1("persist_lockout", i1, 1'b1);
        step(4'b0001, 24'h000259, 1'b0);
        chk1("persist_unlock", i1, 1'b0);

        // Two-slot lot: fill it, gate refuses, Egreso drains and saturates at 0.
        step(4'b1000, 24'h0, 1'b0);
        chkn("cap2_reset_ocup", {2'b00, o2}, 4'd0);
        for (int n = 0; n < 2; n++) begin
            step(4'b0100, 24'h0, 1'b0);
            step(4'b0001, 24'h000259, 1'b0);
            step(4'b0010, 24'h0, 1'b0);
        end
        chkn("cap2_full_ocup", {2'b00, o2}, 4'd2);
        chk1("cap2_lleno", l2, 1'b1);
        step(4'b0100, 24'h0, 1'b0);
        chk1("cap2_refuse_cerrar", c2, 1'b1);
        step(4'b0101, 24'h000259, 1'b0);
        chk1("cap2_refuse_abrir", a2, 1'b0);
        step(4'b0000, 24'h0, 1'b1);
        chkn("cap2_egreso1_ocup", {2'b00, o2}, 4'd1);
        chk1("cap2_egreso1_lleno", l2, 1'b0);
        step(4'b0000, 24'h0, 1'b1);
        chkn("cap2_egreso2_ocup", {2'b00, o2}, 4'd0);
        step(4'b0000, 24'h0, 1'b1);
        chkn("cap2_egreso_at_zero", {2'b00, o2}, 4'd0);

        // Six-digit key: non-BCD digit counts as wrong; reset while open.
        step(4'b1000, 24'h0, 1'b0);
        step(4'b0100, 24'h0, 1'b0);
        for (int n = 0; n < 2; n++) begin
            step(4'b0001, 24'h12345A, 1'b0);
            chk1($sformatf("dig6_wrong%0d_abrir", n), a3, 1'b0);
            chk1($sformatf("dig6_wrong%0d_alrmint", n), i3, 1'b0);
        end
        step(4'b0001, 24'h12345A, 1'b0);
        chk1("dig6_lockout", i3, 1'b1);
        step(4'b0001, 24'h123456, 1'b0);
        chk1("dig6_unlock", i3, 1'b0);
        step(4'b0100, 24'h0, 1'b0);
        step(4'b0001, 24'h123456, 1'b0);
        chk1("dig6_open", a3, 1'b1);
        step(4'b0010, 24'h0, 1'b0);
        chkn("dig6_ocup", o3, 4'd1);
        step(4'b0100, 24'h0, 1'b0);
        step(4'b0001, 24'h123456, 1'b0);
        chk1("dig6_open2", a3, 1'b1);
        step(4'b1100, 24'h0, 1'b0);
        chk1("dig6_reset_abrir", a3, 1'b0);
        chk1("dig6_reset_cerrar", c3, 1'b1);
        chkn("dig6_reset_ocup", o3, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
